// File: rtl/dsf_video_pkg.sv
// Shared video timing, playfield geometry, sprite artwork and colours for the
// player sprite renderer and its VGA timing generator.
package dsf_video_pkg;

   localparam logic [9:0] H_VISIBLE    = 10'd640;
   localparam logic [9:0] H_SYNC_START = 10'd656;
   localparam logic [9:0] H_SYNC_END   = 10'd751;
   localparam logic [9:0] H_TOTAL      = 10'd800;
   localparam logic [9:0] V_VISIBLE    = 10'd480;
   localparam logic [9:0] V_SYNC_START = 10'd490;
   localparam logic [9:0] V_SYNC_END   = 10'd491;
   localparam logic [9:0] V_TOTAL      = 10'd525;

   localparam logic [6:0] GRID_W     = 7'd80;
   localparam logic [6:0] GRID_H     = 7'd60;
   localparam int         CELL       = 8;
   localparam int         CELL_SHIFT = $clog2(CELL);

   localparam logic [11:0] PLAYER_COLOR = 12'hFFF;
   localparam logic [11:0] BG_COLOR     = 12'h112;

   localparam logic [3:0] STATE_PLAYING = 4'd2;

   // Row 0 (top) is the least significant byte; bit 0 of each row is the leftmost pixel.
   localparam logic [7:0][7:0] SPRITE_ROM = {
      8'h03, 8'h5A, 8'h24, 8'hFF, 8'hFF, 8'hDB, 8'h7E, 8'h3C
   };

   typedef struct packed {
      logic [3:0] state;
      logic [6:0] x;
      logic [6:0] y;
   } player_pos_t;

   function automatic logic sprite_bit(input logic [2:0] row, input logic [2:0] col);
      return SPRITE_ROM[row][col];
   endfunction

endpackage

// File: rtl/player_sprite_renderer_vga_timing.sv
// 640x480@60 timing generator: 25 MHz pixel tick from a 50 MHz clock, h/v
// counters, raw sync/visible flags and a registered start-of-frame pulse.
module vga_timing
   import dsf_video_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   output logic       pix_en,
   output logic [9:0] h,
   output logic [9:0] v,
   output logic       hsync_raw,
   output logic       vsync_raw,
   output logic       visible,
   output logic       frame_start
);

   // frame_start is registered so it lines up with the registered pixel outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pix_en      <= 1'b0;
         h           <= '0;
         v           <= '0;
         frame_start <= 1'b0;
      end else begin
         pix_en      <= ~pix_en;
         frame_start <= pix_en && (h == 10'd0) && (v == 10'd0);
         if (pix_en) begin
            if (h == H_TOTAL - 10'd1) begin
               h <= '0;
               v <= (v == V_TOTAL - 10'd1) ? 10'd0 : v + 10'd1;
            end else begin
               h <= h + 10'd1;
            end
         end
      end
   end

   assign hsync_raw = !((h >= H_SYNC_START) && (h <= H_SYNC_END));
   assign vsync_raw = !((v >= V_SYNC_START) && (v <= V_SYNC_END));
   assign visible   = (h < H_VISIBLE) && (v < V_VISIBLE);

endmodule

// File: rtl/player_sprite_renderer.sv
// Overlays the player sprite on a flat background and drives the VGA pins.
// Player position is sampled once per frame at the start of vblank.
module player_sprite_renderer
   import dsf_video_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  state,
   input  logic [6:0]  player_x,
   input  logic [6:0]  player_y,
   output logic        hsync,
   output logic        vsync,
   output logic        de,
   output logic [11:0] rgb,
   output logic        frame_start
);

   logic        pix_en;
   logic [9:0]  h;
   logic [9:0]  v;
   logic        hsync_raw;
   logic        vsync_raw;
   logic        visible;
   player_pos_t pos;
   logic [6:0]  sprite_row;
   logic [9:0]  cell_col;
   logic [9:0]  cell_row;
   logic        hit;

   vga_timing u_timing (
      .clk         (clk),
      .rst         (rst),
      .pix_en      (pix_en),
      .h           (h),
      .v           (v),
      .hsync_raw   (hsync_raw),
      .vsync_raw   (vsync_raw),
      .visible     (visible),
      .frame_start (frame_start)
   );

   // Capturing at the first vblank tick keeps the sprite from tearing mid-frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pos <= '0;
      end else if (pix_en && (h == 10'd0) && (v == V_VISIBLE)) begin
         pos.state <= state;
         pos.x     <= (player_x > GRID_W - 7'd1) ? GRID_W - 7'd1 : player_x;
         pos.y     <= (player_y > GRID_H - 7'd1) ? GRID_H - 7'd1 : player_y;
      end
   end

   // Game y counts upward while screen rows count downward.
   assign sprite_row = GRID_H - 7'd1 - pos.y;
   assign cell_col   = h >> CELL_SHIFT;
   assign cell_row   = v >> CELL_SHIFT;
   assign hit        = (pos.state == STATE_PLAYING)
                     && (cell_col == {3'b000, pos.x})
                     && (cell_row == {3'b000, sprite_row})
                     && sprite_bit(v[2:0], h[2:0]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hsync <= 1'b1;
         vsync <= 1'b1;
         de    <= 1'b0;
         rgb   <= '0;
      end else if (pix_en) begin
         hsync <= hsync_raw;
         vsync <= vsync_raw;
         de    <= visible;
         rgb   <= visible ? (hit ? PLAYER_COLOR : BG_COLOR) : 12'h000;
      end
   end

endmodule

// File: tb/tb_player_sprite_renderer.sv
// Directed bench for player_sprite_renderer: reset, line/frame timing, sprite
// placement, once-per-frame latching, clamping, state gating and mid-frame reset.
module tb_player_sprite_renderer;

   localparam logic [11:0] BG = 12'h112;
   localparam logic [11:0] PC = 12'hFFF;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  state = 4'd0;
   logic [6:0]  player_x = 7'd0;
   logic [6:0]  player_y = 7'd0;
   logic        hsync;
   logic        vsync;
   logic        de;
   logic [11:0] rgb;
   logic        frame_start;

   int     assertions = 0;
   int     failures = 0;
   longint cyc = 0;
   longint anchorCyc = 0;
   longint firstAnchor = 0;
   int     curClk = 0;
   int     waited;

   player_sprite_renderer dut (
      .clk         (clk),
      .rst         (rst),
      .state       (state),
      .player_x    (player_x),
      .player_y    (player_y),
      .hsync       (hsync),
      .vsync       (vsync),
      .de          (de),
      .rgb         (rgb),
      .frame_start (frame_start)
   );

   always #10 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertions++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] s, input logic [6:0] x, input logic [6:0] y);
      state    = s;
      player_x = x;
      player_y = y;
   endtask

   // Outputs for pixel p of the current frame are visible 2*p clk after the frame anchor.
   task automatic seekPixel(input int h, input int v);
      int target;
      target = 2 * (v * 800 + h);
      while (curClk < target) begin
         @(negedge clk);
         curClk++;
      end
   endtask

   task automatic checkRgb(input string tag, input int h, input int v, input logic [11:0] expected);
      seekPixel(h, v);
      checkOutput(tag, {20'b0, rgb}, {20'b0, expected});
   endtask

   task automatic waitFrameStart(output int n);
      n = 0;
      while (frame_start !== 1'b1 && n < 900000) begin
         @(negedge clk);
         n++;
      end
      checkOutput("frame_start_seen", {31'b0, frame_start}, 32'd1);
      curClk    = 0;
      anchorCyc = cyc;
   endtask

   initial begin
      int deCount;
      int hsLow;
      int firstLow;

      #1 rst = 1'b1;
      repeat (5) @(negedge clk);
      checkOutput("reset_hsync", {31'b0, hsync}, 32'd1);
      checkOutput("reset_vsync", {31'b0, vsync}, 32'd1);
      checkOutput("reset_de", {31'b0, de}, 32'd0);
      checkOutput("reset_rgb", {20'b0, rgb}, 32'd0);
      checkOutput("reset_frame_start", {31'b0, frame_start}, 32'd0);
      repeat (5) @(negedge clk);
      rst = 1'b0;
      $display("[TB] reset released");

      waitFrameStart(waited);
      checkOutput("first_frame_start_delay", waited, 32'd2);
      firstAnchor = anchorCyc;
      checkOutput("f0_origin_de", {31'b0, de}, 32'd1);
      checkOutput("f0_origin_rgb", {20'b0, rgb}, {20'b0, BG});
      checkOutput("f0_origin_hsync", {31'b0, hsync}, 32'd1);
      @(negedge clk);
      curClk++;
      checkOutput("frame_start_one_clk", {31'b0, frame_start}, 32'd0);

      deCount  = 0;
      hsLow    = 0;
      firstLow = -1;
      for (int h = 0; h < 800; h++) begin
         seekPixel(h, 1);
         if (de === 1'b1) deCount++;
         if (hsync === 1'b0) begin
            hsLow++;
            if (firstLow < 0) firstLow = h;
         end
      end
      checkOutput("line_de_ticks", deCount, 32'd640);
      checkOutput("line_hsync_low_ticks", hsLow, 32'd96);
      checkOutput("line_hsync_start", firstLow, 32'd656);

      checkRgb("f0_no_sprite", 2, 2, BG);
      seekPixel(639, 2);
      checkOutput("last_visible_de", {31'b0, de}, 32'd1);
      checkRgb("blank_rgb", 640, 2, 12'h000);
      checkOutput("blank_de", {31'b0, de}, 32'd0);

      seekPixel(0, 100);
      applyStimulus(4'd2, 7'd0, 7'd59);
      seekPixel(639, 479);
      checkOutput("last_line_de", {31'b0, de}, 32'd1);
      seekPixel(0, 480);
      checkOutput("vblank_de", {31'b0, de}, 32'd0);
      seekPixel(799, 489);
      checkOutput("vsync_before", {31'b0, vsync}, 32'd1);
      seekPixel(0, 490);
      checkOutput("vsync_first", {31'b0, vsync}, 32'd0);
      seekPixel(799, 491);
      checkOutput("vsync_last", {31'b0, vsync}, 32'd0);
      seekPixel(0, 492);
      checkOutput("vsync_after", {31'b0, vsync}, 32'd1);

      waitFrameStart(waited);
      checkOutput("frame_period_clk", 32'(anchorCyc - firstAnchor), 32'd840000);
      checkRgb("tl_r0_c0", 0, 0, BG);
      checkRgb("tl_r0_c2", 2, 0, PC);
      checkRgb("tl_r0_c5", 5, 0, PC);
      checkRgb("tl_r0_c6", 6, 0, BG);
      checkRgb("tl_next_cell", 8, 0, BG);
      checkRgb("tl_r2_c2", 2, 2, BG);
      checkRgb("tl_r2_c3", 3, 2, PC);
      seekPixel(0, 4);
      applyStimulus(4'd2, 7'd100, 7'd70);
      checkRgb("mid_r5_c3", 3, 5, BG);
      checkRgb("mid_r5_c5", 5, 5, PC);
      checkRgb("mid_no_new_pos", 632, 5, BG);
      checkRgb("mid_r7_c0", 0, 7, PC);
      checkRgb("mid_r7_c1", 1, 7, PC);
      checkRgb("mid_r7_c7", 7, 7, BG);
      checkRgb("tl_below", 2, 8, BG);

      waitFrameStart(waited);
      checkRgb("clamp_r0_c0", 632, 0, BG);
      checkRgb("clamp_r0_c2", 634, 0, PC);
      checkRgb("clamp_left", 631, 3, BG);
      checkRgb("clamp_r3_c7", 639, 3, PC);
      checkRgb("clamp_r7_c0", 632, 7, PC);
      checkRgb("clamp_r7_c1", 633, 7, PC);
      checkRgb("clamp_r7_c2", 634, 7, BG);
      checkRgb("clamp_below", 632, 8, BG);
      applyStimulus(4'd3, 7'd100, 7'd70);

      waitFrameStart(waited);
      checkRgb("gated_r0_c2", 634, 0, BG);
      checkRgb("gated_r3_c7", 639, 3, BG);
      checkRgb("gated_blank", 700, 3, 12'h000);
      seekPixel(300, 10);
      checkOutput("pre_reset_de", {31'b0, de}, 32'd1);
      rst = 1'b1;
      #1;
      checkOutput("async_reset_de", {31'b0, de}, 32'd0);
      checkOutput("async_reset_rgb", {20'b0, rgb}, 32'd0);
      checkOutput("async_reset_hsync", {31'b0, hsync}, 32'd1);
      checkOutput("async_reset_vsync", {31'b0, vsync}, 32'd1);
      checkOutput("async_reset_frame_start", {31'b0, frame_start}, 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      $display("[TB] mid-frame reset released");

      waitFrameStart(waited);
      checkOutput("restart_frame_start_delay", waited, 32'd2);
      checkOutput("restart_origin_rgb", {20'b0, rgb}, {20'b0, BG});
      seekPixel(656, 0);
      checkOutput("restart_hsync_align", {31'b0, hsync}, 32'd0);
      checkRgb("restart_no_sprite", 639, 3, BG);

      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
